// File: rtl/sad_min_tracker_if.sv
// Candidate stream in, winning-candidate result out, plus the window abort.
// The master side is the upstream/downstream pair, the slave side is the tracker.
interface sad_min_tracker_if #(
    parameter int BIT_WIDTH      = 14,
    parameter int NUM_CANDIDATES = 16,
    parameter int INDEX_WIDTH    = $clog2(NUM_CANDIDATES)
);
    logic                   abort;
    logic                   in_valid;
    logic                   in_ready;
    logic [BIT_WIDTH-1:0]   in_sad;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [BIT_WIDTH-1:0]   out_sad;
    logic [INDEX_WIDTH-1:0] out_index;
    logic [INDEX_WIDTH:0]   out_count;
    logic                   out_short;

    modport master (
        output abort, in_valid, in_sad, in_last, out_ready,
        input  in_ready, out_valid, out_sad, out_index, out_count, out_short
    );

    modport slave (
        input  abort, in_valid, in_sad, in_last, out_ready,
        output in_ready, out_valid, out_sad, out_index, out_count, out_short
    );
endinterface

// File: rtl/sad_min_tracker.sv
// Streaming minimum-SAD selector: keeps a running minimum and its arrival
// index over one search window, then holds the winner until downstream takes it.
module sad_min_tracker #(
    parameter int BIT_WIDTH      = 14,
    parameter int NUM_CANDIDATES = 16,
    parameter int INDEX_WIDTH    = $clog2(NUM_CANDIDATES)
) (
    input logic               clk,
    input logic               rst,
    sad_min_tracker_if.slave  bus
);
    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [INDEX_WIDTH:0] NUM_CNT  = (INDEX_WIDTH+1)'(NUM_CANDIDATES);
    localparam logic [INDEX_WIDTH:0] LAST_CNT = NUM_CNT - 1'b1;

    state_t                 state;
    state_t                 next_state;
    logic [INDEX_WIDTH:0]   count;
    logic [INDEX_WIDTH:0]   count_inc;
    logic [BIT_WIDTH-1:0]   run_sad;
    logic [INDEX_WIDTH-1:0] run_idx;
    logic [BIT_WIDTH-1:0]   cand_sad;
    logic [INDEX_WIDTH-1:0] cand_idx;
    logic                   take;
    logic                   accept;
    logic                   close;
    logic [BIT_WIDTH-1:0]   out_sad_q;
    logic [INDEX_WIDTH-1:0] out_index_q;
    logic [INDEX_WIDTH:0]   out_count_q;
    logic                   out_short_q;

    assign bus.out_sad   = out_sad_q;
    assign bus.out_index = out_index_q;
    assign bus.out_count = out_count_q;
    assign bus.out_short = out_short_q;

    // Merge the incoming candidate with the running minimum; ties keep the earlier one.
    always_comb begin
        count_inc = count + 1'b1;
        take      = (count == '0) || (bus.in_sad < run_sad);
        cand_sad  = take ? bus.in_sad : run_sad;
        cand_idx  = take ? count[INDEX_WIDTH-1:0] : run_idx;
        accept    = bus.in_valid && bus.in_ready;
        close     = accept && (bus.in_last || (count == LAST_CNT));
    end

    // State register; reset parks the tracker in COLLECT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Close a window on its last accept, release the result on handshake, abort always returns to COLLECT.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (!bus.abort && close) next_state = HOLD;
            HOLD:    if (bus.abort || bus.out_ready) next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // Handshake flags follow the state, forced low while reset is asserted.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        if (!rst) begin
            case (state)
                COLLECT: bus.in_ready  = 1'b1;
                HOLD:    bus.out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Running minimum and result registers; the result is captured on the closing accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            run_sad     <= '1;
            run_idx     <= '0;
            out_sad_q   <= '1;
            out_index_q <= '0;
            out_count_q <= '0;
            out_short_q <= 1'b0;
        end else if (bus.abort) begin
            count <= '0;
        end else if (close) begin
            out_sad_q   <= cand_sad;
            out_index_q <= cand_idx;
            out_count_q <= count_inc;
            out_short_q <= (count_inc < NUM_CNT);
            count       <= '0;
        end else if (accept) begin
            count   <= count_inc;
            run_sad <= cand_sad;
            run_idx <= cand_idx;
        end
    end
endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker with a four-candidate window.
module tb_sad_min_tracker;
    localparam int BW = 14;
    localparam int NC = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [BW-1:0] sad;
        logic [IW-1:0] idx;
        logic [IW:0]   cnt;
        logic          shrt;
    } result_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    result_t exp_q[$];

    sad_min_tracker_if #(.BIT_WIDTH(BW), .NUM_CANDIDATES(NC)) bus ();

    sad_min_tracker #(.BIT_WIDTH(BW), .NUM_CANDIDATES(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic result_t observed();
        return result_t'({bus.out_sad, bus.out_index, bus.out_count, bus.out_short});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one window; when it is expected to close with a result, push the reference first.
    task automatic play_window(input int vals[4], input int n, input bit use_last, input bit expect_result);
        int best;
        int bi;
        int t;
        if (expect_result) begin
            best = vals[0];
            bi   = 0;
            for (int i = 1; i < n; i++) begin
                if (vals[i] < best) begin
                    best = vals[i];
                    bi   = i;
                end
            end
            exp_q.push_back('{sad: BW'(best), idx: IW'(bi), cnt: (IW+1)'(n), shrt: (n < NC)});
        end
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 20) begin
                tick();
                t++;
            end
            if (t >= 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL in_ready_timeout: got %b expected 1", bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_sad   = BW'(vals[i]);
            bus.in_last  = use_last && (i == n - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (observed() !== result_t'({14'h3FFF, 2'd0, 3'd0, 1'b0}))
            begin errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", observed(), result_t'({14'h3FFF, 2'd0, 3'd0, 1'b0})); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        result_t e;
        play_window('{9, 3, 7, 5}, 4, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: got %b expected 1", bus.out_valid); end
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin errors++; $display("[TB] FAIL basic_result: got %h expected %h", observed(), e); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL basic_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_ties();
        result_t e;
        play_window('{6, 2, 2, 8}, 4, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL tie_pair: got %h expected %h", observed(), e); end
        tick();
        play_window('{4, 4, 4, 4}, 4, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL tie_all: got %h expected %h", observed(), e); end
        tick();
    endtask

    task automatic test_short();
        result_t e;
        play_window('{12, 10, 0, 0}, 2, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL short_window: got %h expected %h", observed(), e); end
        tick();
        play_window('{1, 2, 3, 0}, 4, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL last_on_full: got %h expected %h", observed(), e); end
        tick();
    endtask

    task automatic test_backpressure();
        result_t e;
        bus.out_ready = 1'b0;
        play_window('{9, 8, 7, 6}, 4, 1'b0, 1'b1);
        e = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observed() !== e)
                begin errors++; $display("[TB] FAIL hold_stable: got valid=%b ready=%b out=%h expected valid=1 ready=0 out=%h", bus.out_valid, bus.in_ready, observed(), e); end
            bus.in_valid = 1'b1;
            bus.in_sad   = '0;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sad !== e.sad)
            begin errors++; $display("[TB] FAIL hold_release: got valid=%b ready=%b sad=%h expected valid=0 ready=1 sad=%h", bus.out_valid, bus.in_ready, bus.out_sad, e.sad); end
        play_window('{7, 5, 6, 0}, 3, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL clean_restart: got %h expected %h", observed(), e); end
        tick();
    endtask

    task automatic test_abort();
        result_t e;
        play_window('{5, 1, 0, 0}, 2, 1'b0, 1'b0);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sad   = '0;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL abort_collect: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
        play_window('{8, 9, 7, 6}, 4, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL after_abort: got %h expected %h", observed(), e); end
        tick();

        play_window('{3, 2, 1, 0}, 3, 1'b0, 1'b0);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sad   = '0;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_on_close: got %b expected 0", bus.out_valid); end
            tick();
        end
        play_window('{10, 11, 0, 0}, 2, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL after_close_abort: got %h expected %h", observed(), e); end
        tick();

        bus.out_ready = 1'b0;
        play_window('{2, 1, 0, 0}, 2, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_before_abort: got %b expected 1", bus.out_valid); end
        bus.abort = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL abort_hold: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        result_t e;
        play_window('{100, 50, 0, 0}, 2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_sad !== 14'h3FFF)
            begin errors++; $display("[TB] FAIL reset_mid: got ready=%b valid=%b sad=%h expected ready=0 valid=0 sad=3fff", bus.in_ready, bus.out_valid, bus.out_sad); end
        rst = 1'b0;
        play_window('{16'h3FFF, 0, 0, 0}, 2, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL extremes: got %h expected %h", observed(), e); end
        tick();
    endtask

    task automatic test_back_to_back();
        result_t e;
        int v[4];
        int n;
        bit lst;
        for (int w = 0; w < 8; w++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 7));
            lst = (n < NC) ? 1'b1 : 1'($urandom_range(0, 1));
            play_window(v, n, lst, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (bus.out_valid !== 1'b1 || observed() !== e) begin errors++; $display("[TB] FAIL random_window_%0d: got %h expected %h", w, observed(), e); end
        end
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sad    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_ties();
        test_short();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Streaming minimum-SAD selector for the motion-estimation search.
- Accepts one candidate SAD per cycle over a search window of up to NUM_CANDIDATES entries.
- Tracks the running minimum and its candidate index, then presents the winner through a valid/ready result handshake.
- Sits between the SAD accumulation array and the motion-vector writeback. Replaces trees of combinational pairwise minimum cells with one sequential unit.

Parameters:
BIT_WIDTH, 14, width of each SAD value
NUM_CANDIDATES, 16, maximum candidates per search window (>=2)
INDEX_WIDTH, $clog2(NUM_CANDIDATES), width of candidate index

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
abort  input  1  drop the current window and any pending result
in_valid  input  1  in_sad is valid this cycle
in_ready  output  1  block can accept a candidate
in_sad  input  BIT_WIDTH  candidate SAD value
in_last  input  1  accepted candidate is the final one of a short window
out_valid  output  1  result is available
out_ready  input  1  downstream accepts the result
out_sad  output  BIT_WIDTH  minimum SAD of the window
out_index  output  INDEX_WIDTH  position (0-based, arrival order) of the minimum
out_count  output  INDEX_WIDTH+1  number of candidates accepted in the window
out_short  output  1  window was closed by in_last before NUM_CANDIDATES

Behaviour:
- Reset is synchronous, active-high, single clock. While rst is high:
  - state goes to COLLECT, count = 0
  - out_valid = 0, in_ready = 0
  - out_sad = all ones, out_index = 0, out_count = 0, out_short = 0
- in_ready is 1 from the first cycle after rst deasserts.
- A candidate is accepted on a cycle with in_valid && in_ready.
- States:
  - COLLECT: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1; all out_* registers stable.
- Running minimum (run_sad, run_idx):
  - On the first accept of a window (count == 0), load the candidate unconditionally.
  - On later accepts, replace only if in_sad < run_sad (unsigned, strictly less).
  - Equal values keep the earlier candidate, so on a tie the lowest index wins.
  - The index of the k-th accepted candidate is k-1. count increments on every accept.
- Window close: an accept with in_last = 1 OR count == NUM_CANDIDATES-1 closes the window. On that same clock edge:
  - out_sad / out_index take the min including the closing candidate.
  - out_count = count+1.
  - out_short = (count+1 < NUM_CANDIDATES).
  - State goes to HOLD.
- Latency: out_valid rises the cycle after the closing accept. There is no combinational path from in_sad to out_*.
- in_last on the NUM_CANDIDATES-th candidate closes the window normally with out_short = 0.
- In HOLD:
  - out_valid && out_ready returns to COLLECT and clears count.
  - out_* keep their values (out_valid = 0) until the next result.
  - in_ready rises in the following cycle; there is no bypass.
- abort (checked after rst, before all else):
  - In COLLECT: discard the partial window, count = 0, remain in COLLECT. A candidate presented the same cycle is dropped.
  - In HOLD: drop the result, out_valid = 0, go to COLLECT.
- Simultaneous abort and closing accept: abort wins and no result is produced.
- Simultaneous abort and out_ready in HOLD: the result is treated as dropped; the upstream must not count it.
- Simultaneous rst and anything else: rst wins.
- in_valid while in_ready = 0 is ignored and not queued; the upstream must hold it.
- out_ready while out_valid = 0 has no effect.
- out_sad saturation is not possible: values pass through unmodified.

Test Plan:
- NUM_CANDIDATES=4, feed 9,3,7,5 back-to-back with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sad=3, out_index=1, out_count=4, out_short=0; in_ready=1 two cycles after.
- Ties: feed 6,2,2,8 -> out_sad=2, out_index=1 (earliest wins). Feed 4,4,4,4 -> out_index=0.
- Short window: feed 12,10 with in_last on 10 -> out_sad=10, out_index=1, out_count=2, out_short=1.
- Back-pressure: hold out_ready=0 for 5 cycles after the result -> out_valid and out_* stable, in_ready=0, in_valid pulses ignored. Release -> accepted in one cycle; the next window starts clean at index 0.
- Abort: feed 5,1, then abort with in_valid=1 (value 0), then a fresh 8,9,7,6 -> out_sad=6, out_index=3, out_count=4. Separately, abort coincident with the closing accept -> no out_valid.
- Reset mid-window after 2 accepts -> out_valid=0, out_sad=all ones (0x3FFF), in_ready=0 during reset. The next window reports index relative to the post-reset start. Extremes: SADs 0x3FFF,0x0000 -> out_sad=0, out_index=1.
